// File: rtl/hash_mem_responder_if.sv
// Host header/result streams, core control and core memory port of hash_mem_responder.
// Latency: none, wiring only.
// Backpressure: in_ready / out_ready give valid-ready flow control; the mem port is never stalled.
interface hash_mem_responder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        core_start;
    logic        core_done;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy;
    logic        err;

    // Responder side
    modport slave (
        input  in_valid, in_data, out_ready, core_done, mem_we, mem_addr, mem_write_data,
        output in_ready, out_valid, out_data, out_last, core_start, message_addr, output_addr,
               mem_read_data, busy, err
    );

    // Host/core side
    modport master (
        output in_valid, in_data, out_ready, core_done, mem_we, mem_addr, mem_write_data,
        input  in_ready, out_valid, out_data, out_last, core_start, message_addr, output_addr,
               mem_read_data, busy, err
    );
endinterface

// File: rtl/hash_mem_responder.sv
// Memory-side responder for the hash core: loads the header, starts the core, serves mem, drains results.
// Latency: mem reads one cycle; core_start the cycle after the last header accept; first result at the done edge.
// Backpressure: in_ready only in LOAD; result word and last flag hold while out_valid && !out_ready.
module hash_mem_responder #(
    parameter int          NUM_NONCES   = 16,
    parameter int          MSG_WORDS    = 20,
    parameter logic [15:0] MESSAGE_ADDR = 16'h0000,
    parameter logic [15:0] OUTPUT_ADDR  = 16'h0040
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hash_mem_responder_if.slave   bus
);
    localparam int          LW        = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int          OW        = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
    localparam logic [15:0] MSG_SPAN  = 16'(MSG_WORDS);
    localparam logic [15:0] OUT_SPAN  = 16'(NUM_NONCES);
    localparam logic [LW-1:0] LAST_LOAD = LW'(MSG_WORDS - 1);
    localparam logic [OW-1:0] LAST_OUT  = OW'(NUM_NONCES - 1);

    typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] load_idx;
    logic [OW-1:0] out_idx;
    logic          done_q;
    logic          err_q;
    logic [31:0]   rd_q;
    logic [31:0]   msg     [MSG_WORDS];
    logic [31:0]   out_buf [NUM_NONCES];

    logic [15:0]   msg_off;
    logic [15:0]   out_off;
    logic          msg_hit;
    logic          out_hit;
    logic [LW-1:0] msg_sel;
    logic [OW-1:0] out_sel;
    logic          accept;
    logic          done_rise;
    logic          wr_ok;

    // Offsets are only turned into buffer indices once the range check has passed,
    // so an address below a region base can never alias into it through wrap-around.
    assign msg_off   = bus.mem_addr - MESSAGE_ADDR;
    assign out_off   = bus.mem_addr - OUTPUT_ADDR;
    assign msg_hit   = (bus.mem_addr >= MESSAGE_ADDR) && (msg_off < MSG_SPAN);
    assign out_hit   = (bus.mem_addr >= OUTPUT_ADDR) && (out_off < OUT_SPAN);
    assign msg_sel   = msg_hit ? msg_off[LW-1:0] : '0;
    assign out_sel   = out_hit ? out_off[OW-1:0] : '0;

    assign accept    = (state == LOAD) && bus.in_valid;
    // Only a fresh rising edge counts, so a done level left over from the last job is ignored
    assign done_rise = bus.core_done && !done_q;
    assign wr_ok     = (state == RUN) && out_hit;

    assign bus.message_addr  = MESSAGE_ADDR;
    assign bus.output_addr   = OUTPUT_ADDR;
    assign bus.mem_read_data = rd_q;
    assign bus.err           = err_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded stream/control outputs
    always_comb begin
        state_nxt      = state;
        bus.in_ready   = 1'b0;
        bus.core_start = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_last   = 1'b0;
        bus.busy       = (state != LOAD);
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (accept && (load_idx == LAST_LOAD)) begin
                    state_nxt = START;
                end
            end
            START: begin
                bus.core_start = 1'b1;
                state_nxt      = RUN;
            end
            RUN: begin
                if (done_rise) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = out_buf[out_idx];
                bus.out_last  = (out_idx == LAST_OUT);
                if (bus.out_ready && (out_idx == LAST_OUT)) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Load/drain counters, done edge history and sticky error on any rejected core write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_idx <= '0;
            out_idx  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= bus.core_done;
            if (accept) begin
                load_idx <= (load_idx == LAST_LOAD) ? '0 : load_idx + 1'b1;
            end
            if ((state == RUN) && done_rise) begin
                out_idx <= '0;
            end else if ((state == DRAIN) && bus.out_ready) begin
                out_idx <= (out_idx == LAST_OUT) ? '0 : out_idx + 1'b1;
            end
            if (bus.mem_we && !wr_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // Registered read port; served in every state, unmapped addresses read as zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (msg_hit) begin
            rd_q <= msg[msg_sel];
        end else if (out_hit) begin
            rd_q <= out_buf[out_sel];
        end else begin
            rd_q <= '0;
        end
    end

    // Buffer storage: header fill in LOAD, result clear at START, core writes in RUN
    always_ff @(posedge clk) begin
        if (accept) begin
            msg[load_idx] <= bus.in_data;
        end
        if (state == START) begin
            for (int i = 0; i < NUM_NONCES; i++) begin
                out_buf[i] <= '0;
            end
        end else if (bus.mem_we && wr_ok) begin
            out_buf[out_sel] <= bus.mem_write_data;
        end
    end
endmodule
